sdr_pixel_batcher: RTL and testbench
====================================

# sdr_pixel_batcher

Collects the raytracer's per-pixel 32-bit colour results into batches and hands each batch to the SDRAM access block as one multi-element write transaction. It sits directly upstream of the SDRAM write master, driving its base-address, element-count, wide write-data and write-start inputs and consuming its write-end pulse. It advances the framebuffer address batch by batch until a frame's pixel count has been written.

## Interface
- BATCH, 64: max 32-bit elements per write transaction; must equal the SDRAM access block's MAX_NWRITE; 1..64.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- frame_start  in  1  one-cycle pulse that starts a frame; honoured only in IDLE.
- fb_baseaddr  in  32  framebuffer byte address; sampled on accepted frame_start.
- frame_npixels  in  30  pixels in the frame; sampled on accepted frame_start.
- pix_valid  in  1  pixel word offered.
- pix_data  in  32  pixel colour word.
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready.
- sdr_baseaddr  out  32  byte address of element 0 of the current batch.
- sdr_nelems  out  30  element count of the current batch, 1..BATCH.
- sdr_writedata  out  32*BATCH  element i at bits [32*i +: 32].
- sdr_writestart  out  1  one-cycle write request.
- sdr_writeend  in  1  one-cycle completion pulse from the SDRAM access block.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse when the whole frame is written.

## Operation
- States:
  - IDLE.
  - FILL.
  - ISSUE.
  - WAIT.
- IDLE
  - On frame_start, latch fb_baseaddr, frame_npixels and written=0.
  - If frame_npixels==0, pulse frame_done next cycle and stay in IDLE.
  - Otherwise, clear count and the buffer, then enter FILL.
- FILL
  - pix_ready=1.
  - Each accept writes pix_data into slot count, then count++.
  - Go to ISSUE after the accept that makes count==BATCH or written+count==frame_npixels.
- ISSUE
  - sdr_writestart=1 for exactly one cycle, then go to WAIT.
  - sdr_nelems=count.
  - sdr_baseaddr = base + 4*written, computed mod 2^32 (address wraps silently).
- WAIT
  - Hold until sdr_writeend is sampled high.
  - Then written += count.
  - If written==frame_npixels: pulse frame_done and go to IDLE.
  - Otherwise: clear count and the buffer, then go to FILL.
- sdr_writedata, sdr_nelems and sdr_baseaddr are registered and stay frozen from ISSUE until the writeend cycle; the SDRAM block reads them combinationally throughout the transaction.
- pix_ready=0 in IDLE, ISSUE and WAIT. No pixel is lost; the producer stalls.
- Unused slots of a partial batch are zero.
- frame_start outside IDLE is ignored; no abort mid-transaction.
- A sdr_writeend received outside WAIT is ignored.
- written and count are 30 bits wide; comparisons are unsigned.

## Timing
- Reset:
  - State goes to IDLE.
  - All outputs go to 0, including sdr_writedata and sdr_baseaddr.
  - count and written clear.
- Reset mid-transaction drops the batch. The SDRAM block is reset on the same line.
- frame_start in cycle t gives pix_ready=1 in cycle t+1.
- The final accept of a batch in cycle t gives sdr_writestart=1 in cycle t+1, and pix_ready=0 from t+1.
- sdr_writeend in cycle w:
  - Next batch: FILL with pix_ready=1 in w+1.
  - Last batch: frame_done=1 and busy=0 in w+1.
- sdr_writestart is never high in two consecutive cycles. This keeps the SDRAM block from re-triggering when it returns to its idle state.
- Throughput: one pixel per cycle while filling, plus 2 cycles overhead per batch, plus the SDRAM transaction time.

## Structure
- Shared package sdr_pkg holds:
  - the state enum (IDLE, FILL, ISSUE, WAIT);
  - ELEM_BYTES=4;
  - the BATCH range check constant, also used by the SDRAM access block.
- Sub-module pix_batch_buf holds the 32*BATCH register with:
  - slot-write decode by index;
  - synchronous clear.
- The top level holds the FSM, counters and address arithmetic.

## Test plan
- Drive frame_npixels=128, BATCH=64, base 0x1000, pixels = index, with a behavioural SDRAM model.
  - Expect two writes: base 0x1000 nelems 64, then base 0x1100 nelems 64.
  - Expect memory word k == k.
  - Expect one frame_done.
- Drive frame_npixels=70.
  - Expect the second write at 0x1100 with nelems 6.
  - Expect slots 6..63 == 0.
  - Expect frame_done one cycle after the second writeend.
- Drive frame_npixels=0.
  - Expect frame_done the cycle after frame_start.
  - Expect no sdr_writestart and pix_ready held 0.
- Hold pix_valid=1 continuously and delay writeend by 20 cycles.
  - Expect pix_ready=0 for the whole of WAIT and no pixel dropped or duplicated.
  - Expect sdr_writedata stable throughout WAIT.
- Pulse frame_start and a stray sdr_writeend while in FILL.
  - Expect both ignored and the frame to complete normally.
- Assert reset mid-WAIT.
  - Expect all outputs at 0 next cycle and IDLE.
  - Expect a new frame afterwards to start at the new fb_baseaddr.

Source files
------------

// File: rtl/sdr_pkg.sv
// Shared SDRAM-path definitions: batcher FSM states, element size and the
// legal range for write-transaction batch sizes.
package sdr_pkg;

  typedef enum logic [1:0] {StIdle, StFill, StIssue, StWait} state_e;

  localparam int unsigned ELEM_BYTES = 4;
  localparam int unsigned BATCH_MIN  = 1;
  localparam int unsigned BATCH_MAX  = 64;

  function automatic bit batch_ok(input int unsigned n);
    return (n >= BATCH_MIN) && (n <= BATCH_MAX);
  endfunction

endpackage

// File: rtl/pix_batch_buf.sv
// Batch staging register: BATCH 32-bit slots, written one slot per cycle by
// index, cleared synchronously before each new batch.
module pix_batch_buf #(
  parameter int unsigned BATCH = 64,
  parameter int unsigned IdxW  = (BATCH > 1) ? $clog2(BATCH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr_i,
  input  logic                  wr_en_i,
  input  logic [IdxW-1:0]       wr_idx_i,
  input  logic [31:0]           wr_data_i,
  output logic [32*BATCH-1:0]   data_o
);

  logic [32*BATCH-1:0] buf_q, buf_d;

  always_comb begin
    buf_d = buf_q;
    if (clr_i) begin
      buf_d = '0;
    end else if (wr_en_i) begin
      for (int unsigned i = 0; i < BATCH; i++) begin
        if (wr_idx_i == IdxW'(i)) begin
          buf_d[32*i +: 32] = wr_data_i;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q <= '0;
    end else begin
      buf_q <= buf_d;
    end
  end

  assign data_o = buf_q;

endmodule

// File: rtl/sdr_pixel_batcher.sv
// Gathers pixel words into batches of up to BATCH elements and issues each batch
// as one SDRAM write, stepping the framebuffer address until the frame is done.
module sdr_pixel_batcher
  import sdr_pkg::*;
#(
  parameter int unsigned BATCH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic [31:0]           fb_baseaddr,
  input  logic [29:0]           frame_npixels,
  input  logic                  pix_valid,
  input  logic [31:0]           pix_data,
  output logic                  pix_ready,
  output logic [31:0]           sdr_baseaddr,
  output logic [29:0]           sdr_nelems,
  output logic [32*BATCH-1:0]   sdr_writedata,
  output logic                  sdr_writestart,
  input  logic                  sdr_writeend,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned IdxW = (BATCH > 1) ? $clog2(BATCH) : 1;

  if (!batch_ok(BATCH)) begin : g_batch_check
    $error("sdr_pixel_batcher: BATCH out of range");
  end

  state_e      state_q, state_d;
  logic [29:0] count_q, count_d;
  logic [29:0] written_q, written_d;
  logic [29:0] npix_q, npix_d;
  logic [31:0] base_q, base_d;
  logic [31:0] addr_q, addr_d;
  logic [29:0] nelems_q, nelems_d;
  logic        done_q, done_d;
  logic        buf_clr, buf_we;
  logic [29:0] count_inc, written_inc;

  assign count_inc   = count_q + 30'd1;
  assign written_inc = written_q + count_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    written_d = written_q;
    npix_d    = npix_q;
    base_d    = base_q;
    addr_d    = addr_q;
    nelems_d  = nelems_q;
    done_d    = 1'b0;
    buf_clr   = 1'b0;
    buf_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          base_d    = fb_baseaddr;
          npix_d    = frame_npixels;
          written_d = '0;
          if (frame_npixels == '0) begin
            done_d = 1'b1;
          end else begin
            count_d = '0;
            buf_clr = 1'b1;
            state_d = StFill;
          end
        end
      end
      StFill: begin
        if (pix_valid) begin
          buf_we  = 1'b1;
          count_d = count_inc;
          if ((count_inc == 30'(BATCH)) || (written_q + count_inc == npix_q)) begin
            state_d  = StIssue;
            nelems_d = count_inc;
            // Byte offset wraps modulo 2^32 along with the base.
            addr_d   = base_q + 32'(written_q) * 32'(ELEM_BYTES);
          end
        end
      end
      StIssue: begin
        state_d = StWait;
      end
      StWait: begin
        if (sdr_writeend) begin
          written_d = written_inc;
          if (written_inc == npix_q) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            count_d = '0;
            buf_clr = 1'b1;
            state_d = StFill;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      written_q <= '0;
      npix_q    <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      nelems_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      written_q <= written_d;
      npix_q    <= npix_d;
      base_q    <= base_d;
      addr_q    <= addr_d;
      nelems_q  <= nelems_d;
      done_q    <= done_d;
    end
  end

  pix_batch_buf #(
    .BATCH (BATCH),
    .IdxW  (IdxW)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (buf_clr),
    .wr_en_i   (buf_we),
    .wr_idx_i  (count_q[IdxW-1:0]),
    .wr_data_i (pix_data),
    .data_o    (sdr_writedata)
  );

  assign pix_ready      = (state_q == StFill);
  assign sdr_writestart = (state_q == StIssue);
  assign busy           = (state_q != StIdle);
  assign frame_done     = done_q;
  assign sdr_baseaddr   = addr_q;
  assign sdr_nelems     = nelems_q;

endmodule

// File: tb/tb_sdr_pixel_batcher.sv
// Directed bench for sdr_pixel_batcher with a behavioural SDRAM responder and
// a queue of expected write transactions.
module tb_sdr_pixel_batcher;

  localparam int unsigned BATCH = 64;
  localparam int unsigned W     = 32 * BATCH;

  logic          clk = 1'b0;
  logic          reset, frame_start, pix_valid, pix_ready;
  logic          sdr_writestart, sdr_writeend, busy, frame_done;
  logic [31:0]   fb_baseaddr, pix_data, sdr_baseaddr;
  logic [29:0]   frame_npixels, sdr_nelems;
  logic [W-1:0]  sdr_writedata;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] base;
    logic [29:0] n;
    logic [31:0] val0;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  sdr_pixel_batcher #(.BATCH(BATCH)) dut (
    .clk            (clk),
    .reset          (reset),
    .frame_start    (frame_start),
    .fb_baseaddr    (fb_baseaddr),
    .frame_npixels  (frame_npixels),
    .pix_valid      (pix_valid),
    .pix_data       (pix_data),
    .pix_ready      (pix_ready),
    .sdr_baseaddr   (sdr_baseaddr),
    .sdr_nelems     (sdr_nelems),
    .sdr_writedata  (sdr_writedata),
    .sdr_writestart (sdr_writestart),
    .sdr_writeend   (sdr_writeend),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wd(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    int bad;
    logic [31:0] o, e;
    bad = -1;
    o = '0;
    e = '0;
    for (int i = int'(BATCH) - 1; i >= 0; i--) begin
      if (obs[32*i +: 32] !== exp[32*i +: 32]) bad = i;
    end
    if (bad >= 0) begin
      o = obs[32*bad +: 32];
      e = exp[32*bad +: 32];
    end
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: slot %0d observed=%0h expected=%0h", tag, bad, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame; SDRAM answers writeend `delay` cycles into WAIT.
  task automatic run_frame(input logic [31:0] base, input int npix, input logic [31:0] val0,
                           input int delay, input bit gaps, input bit stray);
    int off, n, m_count, m_written, sent, wcnt;
    bit exp_ready, exp_ws, exp_done, in_txn, done_seen, stray_done;
    bit nx_ready, nx_ws, nx_done;
    txn_t t, cur;
    logic [W-1:0] snap, exp_wd;
    off = 0;
    while (off < npix) begin
      n      = (npix - off > int'(BATCH)) ? int'(BATCH) : npix - off;
      t.base = base + 32'(4 * off);
      t.n    = 30'(n);
      t.val0 = val0 + 32'(off);
      exp_q.push_back(t);
      off += n;
    end
    fb_baseaddr   = base;
    frame_npixels = 30'(npix);
    frame_start   = 1'b1;
    pix_valid     = 1'b0;
    tick();
    m_count = 0; m_written = 0; sent = 0; wcnt = 0;
    in_txn = 0; done_seen = 0; stray_done = !stray;
    exp_ready = 1; exp_ws = 0; exp_done = 0;
    snap = '0;
    for (int budget = 0; budget < 20000; budget++) begin
      frame_start  = 1'b0;
      sdr_writeend = 1'b0;
      chk("pix_ready", 64'(pix_ready), 64'(exp_ready));
      chk("writestart", 64'(sdr_writestart), 64'(exp_ws));
      chk("frame_done", 64'(frame_done), 64'(exp_done));
      chk("busy", 64'(busy), 64'(!exp_done));
      if (exp_done) begin
        done_seen = 1;
        break;
      end
      nx_ready = exp_ready; nx_ws = 0; nx_done = 0;
      if (sdr_writestart) begin
        chk("txn_pending", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          chk("baseaddr", 64'(sdr_baseaddr), 64'(cur.base));
          chk("nelems", 64'(sdr_nelems), 64'(cur.n));
          exp_wd = '0;
          for (int i = 0; i < int'(cur.n); i++) exp_wd[32*i +: 32] = cur.val0 + 32'(i);
          chk_wd("writedata", sdr_writedata, exp_wd);
        end
        for (int i = 0; i < int'(sdr_nelems) && i < int'(BATCH); i++) begin
          mem[sdr_baseaddr + 32'(4 * i)] = sdr_writedata[32*i +: 32];
        end
        snap   = sdr_writedata;
        in_txn = 1;
        wcnt   = delay;
      end else if (in_txn) begin
        chk_wd("wd_stable", sdr_writedata, snap);
        if (wcnt == 0) begin
          sdr_writeend = 1'b1;
          in_txn       = 0;
          m_written   += m_count;
          m_count      = 0;
          if (m_written == npix) nx_done = 1;
          else nx_ready = 1;
        end else begin
          wcnt--;
        end
      end
      if (!stray_done && exp_ready && m_count == 10) begin
        frame_start   = 1'b1;
        fb_baseaddr   = 32'hDEAD_0000;
        frame_npixels = 30'd1;
        sdr_writeend  = 1'b1;
        stray_done    = 1;
      end
      pix_valid = (sent < npix) && (gaps ? ($urandom_range(0, 3) != 0) : 1'b1);
      pix_data  = val0 + 32'(sent);
      if (pix_valid && pix_ready) sent++;
      if (pix_valid && exp_ready) begin
        m_count++;
        if (m_count == int'(BATCH) || m_written + m_count == npix) begin
          nx_ready = 0;
          nx_ws    = 1;
        end
      end
      exp_ready = nx_ready; exp_ws = nx_ws; exp_done = nx_done;
      tick();
    end
    chk("frame_completed", 64'(done_seen), 64'(1));
    frame_start  = 1'b0;
    sdr_writeend = 1'b0;
    pix_valid    = 1'b0;
    tick();
    chk("done_one_pulse", 64'(frame_done), 64'(0));
    chk("txn_queue_empty", 64'(exp_q.size()), 64'(0));
    chk("pixels_sent", 64'(sent), 64'(npix));
  endtask

  initial begin : main
    int seen;
    logic [31:0] a;
    reset = 1'b1; frame_start = 1'b0; fb_baseaddr = '0; frame_npixels = '0;
    pix_valid = 1'b0; pix_data = '0; sdr_writeend = 1'b0;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ready", 64'(pix_ready), 64'(0));
    chk("rst_ws", 64'(sdr_writestart), 64'(0));
    chk("rst_done", 64'(frame_done), 64'(0));
    chk("rst_base", 64'(sdr_baseaddr), 64'(0));
    chk("rst_nelems", 64'(sdr_nelems), 64'(0));
    chk_wd("rst_wd", sdr_writedata, '0);
    reset = 1'b0;
    tick();

    // Two full batches, pixels = index
    run_frame(32'h0000_1000, 128, 32'h0, 2, 0, 0);
    for (int k = 0; k < 128; k++) begin
      a = 32'h1000 + 32'(4 * k);
      chk("mem_word", mem.exists(a) ? 64'(mem[a]) : 64'hFFFF_FFFF_FFFF_FFFF, 64'(k));
    end

    // Partial second batch, bursty producer
    run_frame(32'h0000_1000, 70, 32'h1000_0000, 0, 1, 0);

    // Empty frame
    fb_baseaddr = 32'h0000_3000; frame_npixels = '0; frame_start = 1'b1; pix_valid = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("zero_done", 64'(frame_done), 64'(1));
    chk("zero_busy", 64'(busy), 64'(0));
    chk("zero_ready", 64'(pix_ready), 64'(0));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("zero_ws", 64'(sdr_writestart), 64'(0));
      chk("zero_ready_hold", 64'(pix_ready), 64'(0));
      chk("zero_done_low", 64'(frame_done), 64'(0));
    end
    pix_valid = 1'b0;

    // Continuous producer, slow SDRAM
    run_frame(32'h0000_4000, 100, 32'h2000_0000, 20, 0, 0);

    // Stray frame_start and writeend during FILL
    run_frame(32'h0000_5000, 80, 32'h3000_0000, 3, 0, 1);

    // Reset in the middle of WAIT
    exp_q.delete();
    fb_baseaddr = 32'h0000_6000; frame_npixels = 30'd64; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    pix_valid   = 1'b1;
    seen = 0;
    for (int b = 0; b < 200 && seen == 0; b++) begin
      pix_data = 32'(b);
      tick();
      if (sdr_writestart) seen = 1;
    end
    chk("mid_ws_seen", 64'(seen), 64'(1));
    pix_valid = 1'b0;
    tick();
    tick();
    chk("mid_busy", 64'(busy), 64'(1));
    reset = 1'b1;
    tick();
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_ready", 64'(pix_ready), 64'(0));
    chk("mid_rst_ws", 64'(sdr_writestart), 64'(0));
    chk("mid_rst_done", 64'(frame_done), 64'(0));
    chk("mid_rst_base", 64'(sdr_baseaddr), 64'(0));
    chk("mid_rst_nelems", 64'(sdr_nelems), 64'(0));
    chk_wd("mid_rst_wd", sdr_writedata, '0);
    reset = 1'b0;
    tick();

    // New frame after reset; second batch address wraps past 2^32
    run_frame(32'hFFFF_FF00, 70, 32'h4000_0000, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
